// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
// Holds the default widths, the starvation limit and the FSM state encoding
// so the datapath and the arbiter agree on them.
package data_mem_arbiter_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_LEN_W        = 4;
  localparam int DEF_STARVE_LIMIT = 4;

  // IDLE : CPU owns memory, EXT request may be accepted
  // GRANT: request latched, CPU still owns memory
  // BURST: EXT beats, CPU stalled if it wants memory
  // DONE : completion pulse, CPU owns memory
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle around the data memory arbiter.
//   cpu_* : MEM-stage load/store strobes, address, data, load data, stall
//   ext_* : loader/debug burst request, grant, beat, read data, done
//   mem_* : single-port data memory (combinational read, write on posedge)
// Modports:
//   slave  - the arbiter's view
//   master - the view of the surrounding CPU, EXT port and memory
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [LEN_W-1:0]  ext_len;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_beat;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;
  logic              ext_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    output ext_gnt, ext_beat, ext_rdata, ext_rvalid, ext_done,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    input  ext_gnt, ext_beat, ext_rdata, ext_rvalid, ext_done,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_arbiter_wait_counter.sv
// arb_wait_counter: counts IDLE cycles in which a pending EXT request lost
// the memory to the CPU. Saturates at LIMIT; at_limit forces the next grant.
// Ports:
//   clk      in  clock
//   rst      in  synchronous reset, active-low
//   inc      in  EXT lost this cycle to the CPU
//   clr      in  request has been granted, start over
//   at_limit out count has reached LIMIT
module arb_wait_counter
  import data_mem_arbiter_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // Clear wins over increment; once at the limit the count simply holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == W'(LIMIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the pipeline
// MEM stage (CPU, priority) and an external burst loader/debug port (EXT).
// Ports:
//   clk  in  clock, all state updates on posedge
//   rst  in  synchronous reset, active-low
//   bus  data_mem_arbiter_if.slave: cpu_*, ext_* and mem_* signal groups
// A request accepted in IDLE at cycle t gives ext_gnt at t+1, beats at
// t+2..t+2+len and ext_done at t+3+len. The CPU is stalled only when it
// wants memory during a beat.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic clk,
  input logic rst,
  data_mem_arbiter_if.slave bus
);

  arb_state_t        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt_q;
  logic              rvalid_q;
  logic              done_q;

  logic cpu_acc;
  logic starved;
  logic wait_inc;
  logic wait_clr;

  assign cpu_acc  = bus.cpu_mem_read | bus.cpu_mem_write;
  assign wait_inc = (state == IDLE) & bus.ext_req & cpu_acc;
  assign wait_clr = (state == GRANT);

  arb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .inc      (wait_inc),
    .clr      (wait_clr),
    .at_limit (starved)
  );

  // Arbitration FSM plus burst bookkeeping. The pulse outputs are registered:
  // gnt is set on entry to GRANT, done on entry to DONE, rvalid one cycle
  // after each read beat. ext_* request fields are only looked at in GRANT,
  // so later changes (other than write data) cannot disturb a burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      beat_cnt <= '0;
      rdata_q  <= '0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ext_req && (!cpu_acc || starved)) begin
            state <= GRANT;
            gnt_q <= 1'b1;
          end
        end
        GRANT: begin
          we_q     <= bus.ext_we;
          addr_q   <= bus.ext_addr;
          beat_cnt <= bus.ext_len;
          state    <= BURST;
        end
        BURST: begin
          addr_q   <= addr_q + 1'b1;
          beat_cnt <= beat_cnt - 1'b1;
          if (!we_q) begin
            rdata_q  <= bus.mem_rdata;
            rvalid_q <= 1'b1;
          end
          if (beat_cnt == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port mux: the CPU owns the memory except during BURST, where its
  // strobes are blocked and it is told to stall instead.
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_read  = bus.cpu_mem_read;
    bus.mem_write = bus.cpu_mem_write;
    bus.cpu_stall = 1'b0;
    bus.ext_beat  = 1'b0;
    if (state == BURST) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = bus.ext_wdata;
      bus.mem_read  = !we_q;
      bus.mem_write = we_q;
      bus.cpu_stall = cpu_acc;
      bus.ext_beat  = 1'b1;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_gnt    = gnt_q;
  assign bus.ext_rdata  = rdata_q;
  assign bus.ext_rvalid = rvalid_q;
  assign bus.ext_done   = done_q;

endmodule
